// File: rtl/sobel_window_ctrl_if.sv
// ---------------------------------------------------------------------------
// sobel_window_ctrl_if
// Bundles the pixel stream, the 3x3 window handed to the Sobel datapath, the
// Sobel result coming back and the coordinate-stamped result stream.
//
//   start      1   begin a new frame (1-cycle pulse)
//   pix_valid  1   pix_in carries a pixel this cycle
//   pix_in     8   grey pixel, raster order, x fastest
//   z0..z8     8   window: z0 z1 z2 = row y-2, z3 z4 z5 = row y-1,
//                  z6 z7 z8 = row y; columns x-2, x-1, x
//   edge_in    8   Sobel result for the window sampled LAT cycles earlier
//   out_valid  1   one strobe per result
//   edge_out   8   registered Sobel result
//   out_x/y    10  centre coordinate of the result
//   busy       1   frame in progress
//   frame_done 1   pulse after the last result of a frame
//
// master: the surrounding system (pixel reader, Sobel datapath, edge-map
//         writer). slave: the window controller.
// ---------------------------------------------------------------------------
interface sobel_window_ctrl_if;
  logic       start;
  logic       pix_valid;
  logic [7:0] pix_in;
  logic [7:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
  logic [7:0] edge_in;
  logic       out_valid;
  logic [7:0] edge_out;
  logic [9:0] out_x;
  logic [9:0] out_y;
  logic       busy;
  logic       frame_done;

  modport master (
    output start, pix_valid, pix_in, edge_in,
    input  z0, z1, z2, z3, z4, z5, z6, z7, z8,
    input  out_valid, edge_out, out_x, out_y, busy, frame_done
  );

  modport slave (
    input  start, pix_valid, pix_in, edge_in,
    output z0, z1, z2, z3, z4, z5, z6, z7, z8,
    output out_valid, edge_out, out_x, out_y, busy, frame_done
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// ---------------------------------------------------------------------------
// sobel_window_ctrl
// Sequences the Sobel edge datapath over a raster-scanned 8-bit grey frame.
// Two line buffers supply the upper two rows of a 3x3 window that slides one
// column per accepted pixel. Each window whose centre lies off the border is
// tagged with its centre coordinate; the tag travels through LAT+1 stages so
// it lines up with edge_in, which is then re-registered as a coordinate-
// stamped result.
//
// Parameters
//   WIDTH   pixels per line (3..1024)
//   HEIGHT  lines per frame (3..1024)
//   LAT     register stages in the Sobel datapath (z* sampled -> edge_in)
//
// Ports
//   clock   system clock, rising edge
//   reset   synchronous, active high
//   bus     sobel_window_ctrl_if.slave (stream, window, result, status)
// ---------------------------------------------------------------------------
module sobel_window_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int LAT    = 3
) (
  input  logic               clock,
  input  logic               reset,
  sobel_window_ctrl_if.slave bus
);

  localparam int XW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DCW = $clog2(LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
  } tag_t;

  state_t         state;
  state_t         state_nxt;
  logic [9:0]     x;
  logic [9:0]     y;
  logic [XW-1:0]  col;
  logic           accept;
  logic           last_col;
  logic           last_row;
  logic           drain_last;
  logic           win_valid;
  logic [DCW-1:0] drain_cnt;
  logic [7:0]     linebuf0 [WIDTH];   // row y-2
  logic [7:0]     linebuf1 [WIDTH];   // row y-1
  logic [7:0]     lb0_rd;
  logic [7:0]     lb1_rd;
  tag_t           tag_pipe [LAT+1];

  assign col        = x[XW-1:0];
  assign accept     = bus.pix_valid && ((state == S_FILL) || (state == S_RUN));
  assign last_col   = (x == 10'(WIDTH - 1));
  assign last_row   = (y == 10'(HEIGHT - 1));
  assign drain_last = (state == S_DRAIN) && (drain_cnt == DCW'(LAT));
  // Columns 0 and 1 of a row still hold pixels of the previous row in the
  // left of the window, and rows 0 and 1 have no complete history above.
  assign win_valid  = accept && (x >= 10'd2) && (y >= 10'd2);

  // Both buffers are read at the same column that is written this cycle,
  // so the read sees the value from one and two rows above.
  assign lb0_rd = linebuf0[col];
  assign lb1_rd = linebuf1[col];

  assign bus.busy = (state != S_IDLE);

  // -------------------------------------------------------------------------
  // Frame sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignment so every flop samples
    // the values that existed before the clock edge.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no branch leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start)                      state_nxt = S_FILL;
      S_FILL:  if (accept && last_col && y == 10'd1) state_nxt = S_RUN;
      S_RUN:   if (accept && last_col && last_row)   state_nxt = S_DRAIN;
      S_DRAIN: if (drain_last)                     state_nxt = S_IDLE;
      default:                                     state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Line buffers
  // -------------------------------------------------------------------------
  // NOTE: the line buffers have no reset; every location is written before
  // it can reach a tagged window, and leaving them unreset lets them map
  // onto plain RAM.
  always_ff @(posedge clock) begin
    if (accept) begin
      linebuf1[col] <= bus.pix_in;
      linebuf0[col] <= lb1_rd;
    end
  end

  // -------------------------------------------------------------------------
  // Window, coordinates, tag pipeline and result register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      x              <= '0;
      y              <= '0;
      drain_cnt      <= '0;
      bus.z0         <= '0;
      bus.z1         <= '0;
      bus.z2         <= '0;
      bus.z3         <= '0;
      bus.z4         <= '0;
      bus.z5         <= '0;
      bus.z6         <= '0;
      bus.z7         <= '0;
      bus.z8         <= '0;
      bus.out_valid  <= 1'b0;
      bus.edge_out   <= '0;
      bus.out_x      <= '0;
      bus.out_y      <= '0;
      bus.frame_done <= 1'b0;
      for (int i = 0; i <= LAT; i++) tag_pipe[i] <= '0;
    end else begin
      // DRAIN lasts LAT+1 cycles: long enough for the final tag to emerge.
      drain_cnt      <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      bus.frame_done <= drain_last;

      if ((state == S_IDLE) && bus.start) begin
        x <= '0;
        y <= '0;
      end else if (accept) begin
        bus.z0 <= bus.z1;
        bus.z1 <= bus.z2;
        bus.z2 <= lb0_rd;
        bus.z3 <= bus.z4;
        bus.z4 <= bus.z5;
        bus.z5 <= lb1_rd;
        bus.z6 <= bus.z7;
        bus.z7 <= bus.z8;
        bus.z8 <= bus.pix_in;
        if (last_col) begin
          x <= '0;
          y <= last_row ? '0 : y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end

      // The tag advances every cycle, independent of pix_valid, because the
      // Sobel datapath also clocks continuously; a held window re-enters the
      // datapath but carries no new tag, so no result is duplicated.
      tag_pipe[0] <= '{valid: win_valid, x: x - 10'd1, y: y - 10'd1};
      for (int i = 1; i <= LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

      bus.out_valid <= tag_pipe[LAT].valid;
      if (tag_pipe[LAT].valid) begin
        bus.edge_out <= bus.edge_in;
        bus.out_x    <= tag_pipe[LAT].x;
        bus.out_y    <= tag_pipe[LAT].y;
      end
    end
  end

endmodule
